// File: rtl/ioctl_sdram_pkg.sv
// rtl/ioctl_sdram_pkg.sv - shared entry type, byte-enable codes and FSM states for the SDRAM writer
package ioctl_sdram_pkg;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

endpackage

// File: rtl/ioctl_sdram_writer_if.sv
// rtl/ioctl_sdram_writer_if.sv - SDRAM write request/acknowledge bus
interface ioctl_sdram_writer_if;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_ack;

    modport master (output mem_req, mem_addr, mem_din, mem_be, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_din, mem_be, output mem_ack);
endinterface

// File: rtl/ioctl_word_fifo.sv
// rtl/ioctl_word_fifo.sv - single-clock word FIFO; pushes while full are discarded
module ioctl_word_fifo
    import ioctl_sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/ioctl_sdram_writer.sv
// rtl/ioctl_sdram_writer.sv - packs ioctl download bytes into 16-bit SDRAM writes with byte enables
// Optional IOCTL_SDRAM_CHECKSUM_EN adds a 16-bit running sum of accepted bytes.
module ioctl_sdram_writer
    import ioctl_sdram_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [5:0]  INDEX      = 6'd0,
    parameter bit          INDEX_ANY  = 1'b1,
    parameter logic [23:0] ADDR_BASE  = 24'd0
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ioctl_download,
    input  logic [7:0]                  ioctl_index,
    input  logic                        ioctl_wr,
    input  logic [24:0]                 ioctl_addr,
    input  logic [7:0]                  ioctl_dout,
    ioctl_sdram_writer_if.master        mem,
    output logic                        rom_loading,
    output logic                        load_done,
    output logic                        overflow
`ifdef IOCTL_SDRAM_CHECKSUM_EN
    ,
    output logic [15:0]                 checksum
`endif
);
    logic        dl_q, dl_d;
    logic        pend_v_q, pend_v_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        side_v_q, side_v_d;
    entry_t      side_q, side_d;
    state_e      state_q, state_d;
    entry_t      out_q, out_d;
    logic        req_q, req_d;
    logic        rom_q, rom_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic        rise, fall, accept, pend_live, push, pop, full, empty;
    logic [23:0] waddr;
    entry_t      push_data, head;
    logic        unused_idx;

    assign unused_idx = ^ioctl_index[7:6];

    ioctl_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        rise      = ioctl_download & ~dl_q;
        fall      = ~ioctl_download & dl_q;
        accept    = ioctl_wr & ioctl_download & (INDEX_ANY | (ioctl_index[5:0] == INDEX));
        waddr     = ioctl_addr[24:1] + ADDR_BASE;
        // A restarted download forgets any half-built word from the previous one.
        pend_live = pend_v_q & ~rise;

        dl_d        = ioctl_download;
        pend_v_d    = pend_live;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        side_v_d    = 1'b0;
        side_d      = side_q;
        push        = 1'b0;
        push_data   = '0;

        // The side slot is only ever loaded on a strobe cycle, so it never collides with one.
        if (side_v_q) begin
            push      = 1'b1;
            push_data = side_q;
        end

        if (accept) begin
            if (!ioctl_addr[0]) begin
                if (pend_live) begin
                    push      = 1'b1;
                    push_data = '{pend_addr_q, {8'h00, pend_data_q}, BE_LO};
                end
                pend_v_d    = 1'b1;
                pend_addr_d = waddr;
                pend_data_d = ioctl_dout;
            end else if (pend_live && pend_addr_q == waddr) begin
                push      = 1'b1;
                push_data = '{waddr, {ioctl_dout, pend_data_q}, BE_WORD};
                pend_v_d  = 1'b0;
            end else if (pend_live) begin
                push      = 1'b1;
                push_data = '{pend_addr_q, {8'h00, pend_data_q}, BE_LO};
                pend_v_d  = 1'b0;
                side_v_d  = 1'b1;
                side_d    = '{waddr, {ioctl_dout, 8'h00}, BE_HI};
            end else begin
                push      = 1'b1;
                push_data = '{waddr, {ioctl_dout, 8'h00}, BE_HI};
            end
        end else if (fall && pend_v_q) begin
            push      = 1'b1;
            push_data = '{pend_addr_q, {8'h00, pend_data_q}, BE_LO};
            pend_v_d  = 1'b0;
        end

        ovf_d = rise ? 1'b0 : ovf_q;
        if (push && full) ovf_d = 1'b1;

        state_d = state_q;
        out_d   = out_q;
        req_d   = req_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                out_d   = head;
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (mem.mem_ack) begin
                if (!empty) begin
                    pop   = 1'b1;
                    out_d = head;
                end else begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rom_d  = rom_q;
        done_d = 1'b0;
        if (rise) begin
            rom_d = 1'b1;
        end else if (rom_q && !ioctl_download && !pend_v_q && !side_v_q && empty && state_q == IDLE) begin
            rom_d  = 1'b0;
            done_d = 1'b1;
        end
    end

`ifdef IOCTL_SDRAM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = rise ? 16'h0000 : sum_q;
        if (accept) sum_d = sum_d + {8'h00, ioctl_dout};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum = sum_q;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            side_v_q    <= 1'b0;
            side_q      <= '0;
            state_q     <= IDLE;
            out_q       <= '0;
            req_q       <= 1'b0;
            rom_q       <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            side_v_q    <= side_v_d;
            side_q      <= side_d;
            state_q     <= state_d;
            out_q       <= out_d;
            req_q       <= req_d;
            rom_q       <= rom_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = out_q.addr;
    assign mem.mem_din  = out_q.data;
    assign mem.mem_be   = out_q.be;
    assign rom_loading  = rom_q;
    assign load_done    = done_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// tb/tb_ioctl_sdram_writer.sv - scoreboard bench for ioctl_sdram_writer
module tb_ioctl_sdram_writer;
    import ioctl_sdram_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        dl    = 1'b0;
    logic        wr    = 1'b0;
    logic [7:0]  idx   = 8'd3;
    logic [7:0]  dout  = 8'h00;
    logic [24:0] addr  = '0;
    logic        rl1, ld1, ov1, rl2, ld2, ov2;
`ifdef IOCTL_SDRAM_CHECKSUM_EN
    logic [15:0] cs1, cs2;
`endif

    ioctl_sdram_writer_if m1 ();
    ioctl_sdram_writer_if m2 ();

    always #5 clk = ~clk;

    ioctl_sdram_writer #(.FIFO_DEPTH(4)) dut (
        .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .mem(m1),
        .rom_loading(rl1), .load_done(ld1), .overflow(ov1)
`ifdef IOCTL_SDRAM_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    ioctl_sdram_writer #(.FIFO_DEPTH(4), .INDEX(6'd2), .INDEX_ANY(1'b0)) dut_idx (
        .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .mem(m2),
        .rom_loading(rl2), .load_done(ld2), .overflow(ov2)
`ifdef IOCTL_SDRAM_CHECKSUM_EN
        , .checksum(cs2)
`endif
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    int     writes   = 0;
    bit     ack_en   = 1'b0;
    bit     idx_req_seen = 1'b0;
    entry_t exp_q[$];
    entry_t sb_got, sb_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_w(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_q.push_back('{a, d, be});
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; dout = d; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int pulses = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ld1) pulses++;
            if (!rl1) begin ok = 1'b1; break; end
        end
        repeat (3) begin @(negedge clk); if (ld1) pulses++; end
        check({tag, "_drained"}, 64'(ok), 64'd1);
        check({tag, "_load_done_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // SDRAM model: acknowledges each request one cycle after it is seen and scores the word.
    always @(negedge clk) begin
        if (ack_en && m1.mem_req && !m1.mem_ack) begin
            sb_got = '{m1.mem_addr, m1.mem_din, m1.mem_be};
            writes++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 64'(sb_got), 64'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_word", 64'(sb_got), 64'(sb_exp));
            end
            m1.mem_ack = 1'b1;
        end else begin
            m1.mem_ack = 1'b0;
        end
        if (m2.mem_req) idx_req_seen = 1'b1;
    end

    initial m2.mem_ack = 1'b0;

    initial begin
        logic [23:0] cap_addr;
        logic [15:0] cap_din;
        int          w0;
        bit          seen;

        m1.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(m1.mem_req), 64'd0);
        check("rst_mem_be", 64'(m1.mem_be), 64'd0);
        check("rst_rom_loading", 64'(rl1), 64'd0);
        check("rst_load_done", 64'(ld1), 64'd0);
        check("rst_overflow", 64'(ov1), 64'd0);
        reset  = 1'b0;
        ack_en = 1'b1;

        // Sequential four-byte file, with request latency measured on the first word.
        @(negedge clk); dl = 1'b1;
        expect_w(24'd0, 16'h2211, BE_WORD);
        expect_w(24'd1, 16'h4433, BE_WORD);
        send(25'd0, 8'h11);
        @(negedge clk); addr = 25'd1; dout = 8'h22; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        check("latency_t1_req", 64'(m1.mem_req), 64'd0);
        @(negedge clk);
        check("latency_t2_req", 64'(m1.mem_req), 64'd1);
        check("t1_rom_loading", 64'(rl1), 64'd1);
        check("idx_rom_loading_during", 64'(rl2), 64'd1);
        send(25'd2, 8'h33);
        send(25'd3, 8'h44);
        @(negedge clk); dl = 1'b0;
        wait_done("t1");
        check("idx_rom_loading_after", 64'(rl2), 64'd0);

        // Odd-length file: trailing byte flushed as a low-byte write on download end.
        @(negedge clk); dl = 1'b1;
        expect_w(24'd0, 16'hBBAA, BE_WORD);
        expect_w(24'd1, 16'h00CC, BE_LO);
        send(25'd0, 8'hAA);
        send(25'd1, 8'hBB);
        send(25'd2, 8'hCC);
        @(negedge clk); dl = 1'b0;
        wait_done("t2");

        // Non-sequential bytes: stranded even byte, then odd byte via the side slot.
        @(negedge clk); dl = 1'b1;
        expect_w(24'd2, 16'h0055, BE_LO);
        expect_w(24'd4, 16'h6600, BE_HI);
        send(25'd4, 8'h55);
        send(25'd9, 8'h66);
        @(negedge clk); dl = 1'b0;
        wait_done("t3");
        check("t3_overflow", 64'(ov1), 64'd0);

        // Stall the SDRAM for 50 cycles across six words: one held, four queued, one dropped.
        ack_en = 1'b0;
        w0 = writes;
        @(negedge clk); dl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_w(24'(i), {8'h80 + 8'(i), 8'h10 + 8'(i)}, BE_WORD);
            send(25'(2 * i), 8'h10 + 8'(i));
            send(25'(2 * i + 1), 8'h80 + 8'(i));
            if (i == 0) begin
                cap_addr = m1.mem_addr;
                cap_din  = m1.mem_din;
            end
        end
        repeat (14) @(negedge clk);
        check("ovf_flag", 64'(ov1), 64'd1);
        check("ovf_req_held", 64'(m1.mem_req), 64'd1);
        check("ovf_addr_stable", 64'(m1.mem_addr), 64'(cap_addr));
        check("ovf_din_stable", 64'(m1.mem_din), 64'h8010);
        check("ovf_no_writes_while_stalled", 64'(writes - w0), 64'd0);
        dl = 1'b0;
        ack_en = 1'b1;
        wait_done("ovf");
        check("ovf_write_count", 64'(writes - w0), 64'd5);
        check("ovf_sticky", 64'(ov1), 64'd1);

        // Reset while a request is outstanding.
        @(negedge clk); dl = 1'b1;
        @(negedge clk);
        check("ovf_clear_on_rise", 64'(ov1), 64'd0);
        ack_en = 1'b0;
        send(25'd0, 8'h5A);
        send(25'd1, 8'hA5);
        check("rst_mid_req_before", 64'(m1.mem_req), 64'd1);
        reset = 1'b1;
        dl    = 1'b0;
        @(negedge clk);
        check("rst_mid_req_after", 64'(m1.mem_req), 64'd0);
        check("rst_mid_rom_loading", 64'(rl1), 64'd0);
        check("rst_mid_load_done", 64'(ld1), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ld1 || m1.mem_req) seen = 1'b1;
        end
        check("rst_mid_quiet", 64'(seen), 64'd0);
        ack_en = 1'b1;

`ifdef IOCTL_SDRAM_CHECKSUM_EN
        @(negedge clk); dl = 1'b1;
        expect_w(24'd0, 16'hFFFF, BE_WORD);
        expect_w(24'd1, 16'h00FF, BE_LO);
        send(25'd0, 8'hFF);
        send(25'd1, 8'hFF);
        send(25'd2, 8'hFF);
        @(negedge clk); dl = 1'b0;
        wait_done("cks");
        check("checksum", 64'(cs1), 64'h02FD);
`endif

        check("idx_filter_no_req", 64'(idx_req_seen), 64'd0);
        check("idx_filter_overflow", 64'(ov2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
